// File: rtl/aliens_pkg.sv
// Formation geometry and hit-state type shared by the alien blocks.
// The movement block imports these too, so its travel limits agree with
// the cell grid decoded by the matrix tracker.
package aliens_pkg;

    // Formation grid
    localparam int COLS         = 7;
    localparam int ROWS         = 4;
    localparam int CELL_W       = 64;
    localparam int CELL_H       = 32;
    localparam int ALIEN_W      = 48;
    localparam int ALIEN_H      = 24;
    localparam int BOTTOM_LIMIT = 400;

    // Derived formation extents
    localparam int FORM_W     = COLS * CELL_W;
    localparam int FORM_H     = ROWS * CELL_H;
    localparam int NUM_ALIENS = COLS * ROWS;

    // Field widths
    localparam int COORD_W = 11;
    localparam int DELTA_W = COORD_W + 1;
    localparam int CX_W    = $clog2(CELL_W);
    localparam int CY_W    = $clog2(CELL_H);
    localparam int COL_W   = $clog2(COLS);
    localparam int ROW_W   = $clog2(ROWS);
    localparam int IDX_W   = $clog2(NUM_ALIENS);
    localparam int CNT_W   = $clog2(NUM_ALIENS + 1);

    // One missile kill per frame: armed until a kill, spent until next frame
    typedef enum logic {
        S_ARMED,
        S_SPENT
    } hit_state_t;

    // Row-major flat index of an alien in the alive matrix
    function automatic logic [IDX_W-1:0] cell_index(
        input logic [ROW_W-1:0] row,
        input logic [COL_W-1:0] col
    );
        return IDX_W'(row) * IDX_W'(COLS) + IDX_W'(col);
    endfunction

endpackage

// File: rtl/aliens_matrix_tracker_if.sv
// Video-side bus of the alien matrix tracker: scan position and formation
// corner in, registered drawing request and bitmap offsets out.
interface aliens_matrix_tracker_if;
    import aliens_pkg::*;

    logic        [COORD_W-1:0] pixelX;
    logic        [COORD_W-1:0] pixelY;
    logic signed [COORD_W-1:0] topLeftX;
    logic signed [COORD_W-1:0] topLeftY;
    logic                      drawingRequest;
    logic        [CX_W-1:0]    offsetX;
    logic        [CY_W-1:0]    offsetY;

    // Scan generator / movement side
    modport master (
        output pixelX, pixelY, topLeftX, topLeftY,
        input  drawingRequest, offsetX, offsetY
    );

    // Tracker side
    modport slave (
        input  pixelX, pixelY, topLeftX, topLeftY,
        output drawingRequest, offsetX, offsetY
    );

endinterface

// File: rtl/aliens_cell_locator.sv
// Combinational pixel-to-cell decode: position of the scan pixel relative
// to the formation corner, split into grid cell and offset inside the cell.
module aliens_cell_locator
    import aliens_pkg::*;
(
    input  logic        [COORD_W-1:0] pixelX,
    input  logic        [COORD_W-1:0] pixelY,
    input  logic signed [COORD_W-1:0] topLeftX,
    input  logic signed [COORD_W-1:0] topLeftY,
    output logic                      inFormation,
    output logic        [ROW_W-1:0]   row,
    output logic        [COL_W-1:0]   col,
    output logic        [CX_W-1:0]    cx,
    output logic        [CY_W-1:0]    cy
);

    localparam logic signed [DELTA_W-1:0] FORM_W_S = DELTA_W'(FORM_W);
    localparam logic signed [DELTA_W-1:0] FORM_H_S = DELTA_W'(FORM_H);

    logic signed [DELTA_W-1:0] dx_p0;
    logic signed [DELTA_W-1:0] dy_p0;
    logic                      inX_p0;
    logic                      inY_p0;

    // Pixel is unsigned, corner is signed: widen both by one bit first
    assign dx_p0 = $signed({1'b0, pixelX}) - $signed({topLeftX[COORD_W-1], topLeftX});
    assign dy_p0 = $signed({1'b0, pixelY}) - $signed({topLeftY[COORD_W-1], topLeftY});

    assign inX_p0 = !dx_p0[DELTA_W-1] && (dx_p0 < FORM_W_S);
    assign inY_p0 = !dy_p0[DELTA_W-1] && (dy_p0 < FORM_H_S);

    assign inFormation = inX_p0 && inY_p0;

    // Cell sizes are powers of two, so cell and offset are plain bit fields
    assign col = dx_p0[CX_W +: COL_W];
    assign row = dy_p0[CY_W +: ROW_W];
    assign cx  = dx_p0[CX_W-1:0];
    assign cy  = dy_p0[CY_W-1:0];

endmodule

// File: rtl/aliens_matrix_tracker.sv
// Alien formation tracker: decides per pixel whether a living alien is
// drawn, keeps the alive matrix and kill counter, accepts at most one
// missile kill per frame, and reports wave-cleared / invasion status.
module aliens_matrix_tracker
    import aliens_pkg::*;
(
    input  logic                          clk,
    input  logic                          resetN,
    input  logic                          startOfFrame,
    input  logic                          isGameMode,
    input  logic                          newWave,
    input  logic                          missileHit,
    aliens_matrix_tracker_if.slave        bus,
    output logic                          alienKilled,
    output logic [CNT_W-1:0]              aliveCount,
    output logic                          allDead,
    output logic                          reachedBottom
);

    localparam int                      BOT_W      = DELTA_W + 1;
    localparam logic [NUM_ALIENS-1:0]   ALL_ALIVE  = '1;
    localparam logic [CNT_W-1:0]        FULL_COUNT = CNT_W'(NUM_ALIENS);
    localparam logic [CX_W-1:0]         ALIEN_W_C  = CX_W'(ALIEN_W);
    localparam logic [CY_W-1:0]         ALIEN_H_C  = CY_W'(ALIEN_H);
    localparam logic signed [BOT_W-1:0] BOTTOM_Y   = BOT_W'(BOTTOM_LIMIT);

    // ---------------- stage 0: combinational geometry ----------------
    logic                   inFormation_p0;
    logic [ROW_W-1:0]       row_p0;
    logic [COL_W-1:0]       col_p0;
    logic [CX_W-1:0]        cx_p0;
    logic [CY_W-1:0]        cy_p0;
    logic [IDX_W-1:0]       idx_p0;
    logic                   vld_p0;

    // ---------------- stage 1: registered pixel decision ----------------
    logic                   vld_p1;
    logic [CX_W-1:0]        offX_p1;
    logic [CY_W-1:0]        offY_p1;
    logic [IDX_W-1:0]       idx_p1;

    // Game state
    logic [NUM_ALIENS-1:0]  alive;
    hit_state_t             state_q;
    hit_state_t             state_d;
    logic                   killAccept;

    // Invasion test
    logic [ROW_W-1:0]       lowRow;
    logic                   anyAlive;
    logic signed [BOT_W-1:0] bottomY;

    aliens_cell_locator u_locator (
        .pixelX      (bus.pixelX),
        .pixelY      (bus.pixelY),
        .topLeftX    (bus.topLeftX),
        .topLeftY    (bus.topLeftY),
        .inFormation (inFormation_p0),
        .row         (row_p0),
        .col         (col_p0),
        .cx          (cx_p0),
        .cy          (cy_p0)
    );

    assign idx_p0 = cell_index(row_p0, col_p0);

    // Row/col are only in range inside the formation, so gate the lookup
    assign vld_p0 = inFormation_p0
                 && (cx_p0 < ALIEN_W_C)
                 && (cy_p0 < ALIEN_H_C)
                 && alive[idx_p0];

    // ---------------- stage 0 -> stage 1 ----------------
    // Register the pixel decision with the offsets and cell it refers to
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            vld_p1  <= 1'b0;
            offX_p1 <= '0;
            offY_p1 <= '0;
            idx_p1  <= '0;
        end else begin
            vld_p1  <= vld_p0;
            offX_p1 <= cx_p0;
            offY_p1 <= cy_p0;
            idx_p1  <= idx_p0;
        end
    end

    assign bus.drawingRequest = vld_p1;
    assign bus.offsetX        = offX_p1;
    assign bus.offsetY        = offY_p1;

    // A hit counts only on a drawn, still-living alien while armed; the
    // alive check covers a second hit on the same alien right after a kill
    // that landed together with startOfFrame. newWave cancels any kill.
    assign killAccept = (state_q == S_ARMED)
                     && missileHit
                     && vld_p1
                     && isGameMode
                     && alive[idx_p1]
                     && !newWave;

    // Hit FSM state register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_ARMED;
        end else begin
            state_q <= state_d;
        end
    end

    // Hit FSM next state: newWave re-arms, a kill spends the frame
    always_comb begin
        state_d = state_q;
        if (newWave) begin
            state_d = S_ARMED;
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (killAccept && !startOfFrame) begin
                        state_d = S_SPENT;
                    end
                end
                S_SPENT: begin
                    if (startOfFrame) begin
                        state_d = S_ARMED;
                    end
                end
                default: state_d = S_ARMED;
            endcase
        end
    end

    // Alive matrix and living-alien counter
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            alive      <= ALL_ALIVE;
            aliveCount <= FULL_COUNT;
        end else if (newWave) begin
            alive      <= ALL_ALIVE;
            aliveCount <= FULL_COUNT;
        end else if (killAccept) begin
            alive[idx_p1] <= 1'b0;
            aliveCount    <= aliveCount - 1'b1;
        end
    end

    // One-cycle kill pulse to the game controller
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            alienKilled <= 1'b0;
        end else begin
            alienKilled <= killAccept;
        end
    end

    assign allDead = (aliveCount == '0);

    // Lowest row that still has a living alien sets the formation bottom
    always_comb begin
        lowRow   = '0;
        anyAlive = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            if (|alive[r*COLS +: COLS]) begin
                lowRow   = ROW_W'(r);
                anyAlive = 1'b1;
            end
        end
    end

    assign bottomY = $signed({{(BOT_W-COORD_W){bus.topLeftY[COORD_W-1]}}, bus.topLeftY})
                   + $signed(BOT_W'(int'(lowRow) * CELL_H + ALIEN_H));

    assign reachedBottom = anyAlive && (bottomY >= BOTTOM_Y);

endmodule

// File: tb/tb_aliens_matrix_tracker.sv
// Bench for aliens_matrix_tracker: directed scenarios with literal
// expectations, then randomized play against a behavioural model that
// works from screen geometry and a per-alien alive table.
module tb_aliens_matrix_tracker;

    localparam int T_COLS   = 7;
    localparam int T_ROWS   = 4;
    localparam int T_CW     = 64;
    localparam int T_CH     = 32;
    localparam int T_AW     = 48;
    localparam int T_AH     = 24;
    localparam int T_LIMIT  = 400;
    localparam int T_N      = T_COLS * T_ROWS;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       isGameMode = 1'b1;
    logic       newWave = 1'b0;
    logic       missileHit = 1'b0;
    logic       alienKilled;
    logic [4:0] aliveCount;
    logic       allDead;
    logic       reachedBottom;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    int tlx = 40;
    int tly = 40;

    // Model state
    bit m_alive [T_N];
    bit m_draw;
    int m_offx;
    int m_offy;
    int m_idx;
    bit m_killed;
    bit m_armed;

    aliens_matrix_tracker_if bus ();

    aliens_matrix_tracker dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .isGameMode    (isGameMode),
        .newWave       (newWave),
        .missileHit    (missileHit),
        .bus           (bus),
        .alienKilled   (alienKilled),
        .aliveCount    (aliveCount),
        .allDead       (allDead),
        .reachedBottom (reachedBottom)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int alive_total();
        int n = 0;
        for (int i = 0; i < T_N; i++) n += int'(m_alive[i]);
        return n;
    endfunction

    function automatic int exp_bottom();
        int low = -1;
        for (int i = 0; i < T_N; i++) if (m_alive[i]) low = i / T_COLS;
        if (low < 0) return 0;
        return ((int'(bus.topLeftY) + low * T_CH + T_AH) >= T_LIMIT) ? 1 : 0;
    endfunction

    // One clock of the game as seen from the screen
    task automatic model_step();
        int dx, dy, row, col, cx, cy;
        bit inF, nd, kill;
        if (!resetN) begin
            for (int i = 0; i < T_N; i++) m_alive[i] = 1'b1;
            m_draw = 0; m_offx = 0; m_offy = 0; m_idx = 0;
            m_killed = 0; m_armed = 1;
            return;
        end
        dx  = int'(bus.pixelX) - int'(bus.topLeftX);
        dy  = int'(bus.pixelY) - int'(bus.topLeftY);
        inF = (dx >= 0) && (dx < T_COLS * T_CW) && (dy >= 0) && (dy < T_ROWS * T_CH);
        col = inF ? dx / T_CW : 0;
        row = inF ? dy / T_CH : 0;
        cx  = inF ? dx % T_CW : 0;
        cy  = inF ? dy % T_CH : 0;
        nd  = inF && (cx < T_AW) && (cy < T_AH) && m_alive[row * T_COLS + col];
        kill = m_armed && missileHit && m_draw && isGameMode && !newWave && m_alive[m_idx];
        if (newWave) begin
            for (int i = 0; i < T_N; i++) m_alive[i] = 1'b1;
            m_armed = 1;
        end else if (kill) begin
            m_alive[m_idx] = 1'b0;
            m_armed = startOfFrame;
        end else if (startOfFrame) begin
            m_armed = 1;
        end
        m_killed = kill;
        m_draw   = nd;
        m_offx   = cx;
        m_offy   = cy;
        m_idx    = row * T_COLS + col;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge resetN);
            model_step();
        end
    end

    // Continuous comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("drawingRequest", int'(bus.drawingRequest), int'(m_draw));
            if (m_draw) begin
                check("offsetX", int'(bus.offsetX), m_offx);
                check("offsetY", int'(bus.offsetY), m_offy);
            end
            check("alienKilled", int'(alienKilled), int'(m_killed));
            check("aliveCount", int'(aliveCount), alive_total());
            check("allDead", int'(allDead), (alive_total() == 0) ? 1 : 0);
            check("reachedBottom", int'(reachedBottom), exp_bottom());
        end
    end

    task automatic pix(input int px, input int py);
        bus.pixelX = 11'(px);
        bus.pixelY = 11'(py);
    endtask

    task automatic set_tl(input int x, input int y);
        tlx = x;
        tly = y;
        bus.topLeftX = 11'(x);
        bus.topLeftY = 11'(y);
    endtask

    // Present pulses for exactly one rising edge; returns 1 time unit after it
    task automatic cyc(input bit hit = 1'b0, input bit sof = 1'b0, input bit nw = 1'b0);
        missileHit   = hit;
        startOfFrame = sof;
        newWave      = nw;
        @(posedge clk);
        #1;
        missileHit   = 1'b0;
        startOfFrame = 1'b0;
        newWave      = 1'b0;
    endtask

    task automatic pix_idx(input int idx);
        pix(tlx + (idx % T_COLS) * T_CW + 3, tly + (idx / T_COLS) * T_CH + 3);
    endtask

    task automatic kill_idx(input int idx);
        cyc(1'b0, 1'b1, 1'b0);
        pix_idx(idx);
        cyc();
        cyc(1'b1);
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int px, py;
        set_tl(40, 40);
        pix(0, 0);
        repeat (3) @(posedge clk);
        #1;
        resetN = 1'b1;
        chk_en = 1'b1;

        check("reset aliveCount", int'(aliveCount), 28);
        check("reset allDead", int'(allDead), 0);
        check("reset alienKilled", int'(alienKilled), 0);
        check("reset drawingRequest", int'(bus.drawingRequest), 0);
        check("reset reachedBottom", int'(reachedBottom), 0);

        pix(40, 40); cyc();
        check("corner draw", int'(bus.drawingRequest), 1);
        check("corner offX", int'(bus.offsetX), 0);
        check("corner offY", int'(bus.offsetY), 0);
        pix(88, 40); cyc();
        check("gap draw", int'(bus.drawingRequest), 0);
        pix(434, 141); cyc();
        check("last draw", int'(bus.drawingRequest), 1);
        check("last offX", int'(bus.offsetX), 10);
        check("last offY", int'(bus.offsetY), 5);
        pix(488, 40); cyc();
        check("outside draw", int'(bus.drawingRequest), 0);

        // Hit outside game mode is ignored
        isGameMode = 1'b0;
        pix(40, 40); cyc();
        cyc(1'b1);
        check("no game kill", int'(alienKilled), 0);
        check("no game count", int'(aliveCount), 28);
        isGameMode = 1'b1;

        // Kill idx 0
        cyc(1'b1);
        check("kill0 pulse", int'(alienKilled), 1);
        check("kill0 count", int'(aliveCount), 27);
        cyc();
        check("kill0 pulse end", int'(alienKilled), 0);
        check("kill0 dead draw", int'(bus.drawingRequest), 0);

        // Second hit in the same frame is ignored
        pix(104, 40); cyc();
        check("idx1 draw", int'(bus.drawingRequest), 1);
        cyc(1'b1);
        check("spent kill", int'(alienKilled), 0);
        check("spent count", int'(aliveCount), 27);
        cyc(1'b0, 1'b1);
        cyc(1'b1);
        check("kill1 pulse", int'(alienKilled), 1);
        check("kill1 count", int'(aliveCount), 26);

        // Clear the wave one kill per frame
        for (int i = 2; i < T_N; i++) kill_idx(i);
        cyc();
        check("wave count", int'(aliveCount), 0);
        check("wave allDead", int'(allDead), 1);
        check("wave bottom", int'(reachedBottom), 0);

        cyc(1'b0, 1'b0, 1'b1);
        check("newWave count", int'(aliveCount), 28);
        check("newWave allDead", int'(allDead), 0);
        pix_idx(0); cyc();
        check("newWave draw0", int'(bus.drawingRequest), 1);

        // Invasion threshold
        set_tl(40, 280); #1;
        check("bottom 280", int'(reachedBottom), 1);
        set_tl(40, 300);
        for (int i = 21; i < T_N; i++) kill_idx(i);
        cyc();
        check("row3 gone count", int'(aliveCount), 21);
        check("bottom 300", int'(reachedBottom), 0);
        set_tl(40, 312); #1;
        check("bottom 312", int'(reachedBottom), 1);

        // newWave beats a same-cycle kill
        set_tl(40, 40);
        cyc(1'b0, 1'b0, 1'b1);
        pix_idx(0); cyc();
        cyc(1'b1, 1'b0, 1'b1);
        check("nw kill pulse", int'(alienKilled), 0);
        check("nw kill count", int'(aliveCount), 28);

        // Reset while spent
        cyc(1'b1);
        check("pre reset kill", int'(aliveCount), 27);
        resetN = 1'b0; #1;
        check("async reset count", int'(aliveCount), 28);
        check("async reset draw", int'(bus.drawingRequest), 0);
        cyc();
        resetN = 1'b1;
        cyc();
        cyc(1'b1);
        check("armed after reset", int'(alienKilled), 1);
        check("count after reset", int'(aliveCount), 27);

        // Randomized play
        for (int n = 0; n < 4000; n++) begin
            if ((n % 64) == 0) begin
                set_tl(int'($urandom_range(0, 250)) - 50, int'($urandom_range(0, 330)));
            end
            px = tlx + int'($urandom_range(0, 500)) - 20;
            py = tly + int'($urandom_range(0, 150)) - 10;
            if (px < 0) px = 0;
            if (py < 0) py = 0;
            pix(px, py);
            isGameMode = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 999) < 2) begin
                resetN = 1'b0;
                cyc();
                resetN = 1'b1;
            end else begin
                cyc($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 3,
                    $urandom_range(0, 999) < 5);
            end
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
